// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: pipeline-side signals of the hazard controller; master drives operands/status, slave is the controller
interface pipe_hazard_if #(parameter int CNT_W = 32);
    logic [4:0]       rs1_ID, rs2_ID, rd_EX;
    logic             rs1_used_ID, rs2_used_ID, mem_read_EX, branch_taken_EX, mem_busy_MEM, trap_req;
    logic             pc_en;
    logic [1:0]       redirect_sel;
    logic             if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush;
    logic             trap_busy, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    modport master (
        output rs1_ID, rs2_ID, rd_EX, rs1_used_ID, rs2_used_ID, mem_read_EX, branch_taken_EX, mem_busy_MEM, trap_req,
        input  pc_en, redirect_sel, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush,
        input  trap_busy, mem_timeout, stall_cnt, flush_cnt
    );
    modport slave (
        input  rs1_ID, rs2_ID, rd_EX, rs1_used_ID, rs2_used_ID, mem_read_EX, branch_taken_EX, mem_busy_MEM, trap_req,
        output pc_en, redirect_sel, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, ex_mem_flush,
        output trap_busy, mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer with mem-wait watchdog, post-trap drain and saturating perf counters
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 32
) (
    input logic          clk,
    input logic          rst,
    pipe_hazard_if.slave h
);
    localparam int WW = $clog2(MEM_TIMEOUT);
    localparam int DW = $clog2(FLUSH_CYCLES + 1);
    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN} state_t;
    state_t           state, state_d;
    logic [WW-1:0]    wait_cnt;
    logic [DW-1:0]    drain_cnt, drain_d;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic active, load_use, fire, trap, stall_mem, br, ld, drn;
    assign active   = state != DRAIN;
    assign load_use = h.mem_read_EX && h.rd_EX != 5'd0 &&
                      ((h.rs1_used_ID && h.rs1_ID == h.rd_EX) || (h.rs2_used_ID && h.rs2_ID == h.rd_EX));
    assign fire      = active && h.mem_busy_MEM && wait_cnt == WW'(MEM_TIMEOUT - 1);
    assign trap      = h.trap_req || fire;
    assign stall_mem = !trap && active && h.mem_busy_MEM;
    assign br        = !trap && active && !h.mem_busy_MEM && h.branch_taken_EX;
    assign ld        = !trap && active && !h.mem_busy_MEM && !h.branch_taken_EX && load_use;
    assign drn       = !trap && !active;
    // Mealy outputs, all forced low while in reset
    assign h.pc_en        = !rst && !(stall_mem || ld || drn);
    assign h.redirect_sel = rst ? 2'd0 : trap ? 2'd2 : br ? 2'd1 : 2'd0;
    assign h.if_id_stall  = !rst && (stall_mem || ld);
    assign h.if_id_flush  = !rst && (trap || drn || br);
    assign h.id_ex_stall  = !rst && stall_mem;
    assign h.id_ex_flush  = !rst && (trap || drn || br || ld);
    assign h.ex_mem_stall = !rst && stall_mem;
    assign h.ex_mem_flush = !rst && (trap || drn);
    assign h.trap_busy    = !rst && !active;
    assign h.mem_timeout  = !rst && fire;
    assign h.stall_cnt    = stall_cnt;
    assign h.flush_cnt    = flush_cnt;
    always_comb begin
        state_d = trap ? DRAIN : drn ? (drain_cnt == DW'(1) ? RUN : DRAIN) : stall_mem ? MEM_WAIT : RUN;
        drain_d = trap ? DW'(FLUSH_CYCLES) : drn ? drain_cnt - DW'(1) : drain_cnt;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_d;
            drain_cnt <= drain_d;
            wait_cnt  <= stall_mem ? wait_cnt + WW'(1) : '0;
            if ((stall_mem || ld) && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
            if ((trap || br) && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors and hand-written sequences for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    pipe_hazard_if #(.CNT_W(4)) a();
    pipe_hazard_if #(.CNT_W(3)) b();
    assign b.rs1_ID = a.rs1_ID;
    assign b.rs2_ID = a.rs2_ID;
    assign b.rd_EX = a.rd_EX;
    assign b.rs1_used_ID = a.rs1_used_ID;
    assign b.rs2_used_ID = a.rs2_used_ID;
    assign b.mem_read_EX = a.mem_read_EX;
    assign b.branch_taken_EX = a.branch_taken_EX;
    assign b.mem_busy_MEM = a.mem_busy_MEM;
    assign b.trap_req = a.trap_req;
    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(64), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .h(a.slave));
    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(3)) dut_b (.clk(clk), .rst(rst), .h(b.slave));
    logic [5:0] ca, cb;
    assign ca = {a.if_id_stall, a.if_id_flush, a.id_ex_stall, a.id_ex_flush, a.ex_mem_stall, a.ex_mem_flush};
    assign cb = {b.if_id_stall, b.if_id_flush, b.id_ex_stall, b.id_ex_flush, b.ex_mem_stall, b.ex_mem_flush};
    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, br, pc;
        logic [1:0] rs;
        logic [5:0] ctl;
    } vec_t;
    vec_t tv[8];
    int total = 0, passed = 0;
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask
    task automatic idle_in();
        a.rs1_ID = 0; a.rs2_ID = 0; a.rd_EX = 0; a.rs1_used_ID = 0; a.rs2_used_ID = 0;
        a.mem_read_EX = 0; a.branch_taken_EX = 0; a.mem_busy_MEM = 0; a.trap_req = 0;
    endtask
    task automatic do_reset();
        @(negedge clk); rst = 1; idle_in();
        @(negedge clk); rst = 0;
    endtask
    initial begin
        tv[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'b000000};
        tv[1] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'b100100};
        tv[2] = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 6'b000000};
        tv[3] = '{5'd3, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 6'b000000};
        tv[4] = '{5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 6'b100100};
        tv[5] = '{5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 6'b000000};
        tv[6] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 6'b010100};
        tv[7] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 6'b010100};
        idle_in();
        // reset: outputs forced low even with trap and busy asserted
        @(negedge clk); a.trap_req = 1; a.mem_busy_MEM = 1;
        #1;
        chk("rst_pc_en", 32'(a.pc_en), 0);
        chk("rst_redir", 32'(a.redirect_sel), 0);
        chk("rst_ctl", 32'(ca), 0);
        chk("rst_trap_busy", 32'(a.trap_busy), 0);
        chk("rst_timeout", 32'(b.mem_timeout), 0);
        @(negedge clk);
        chk("rst_stall_cnt", 32'(a.stall_cnt), 0);
        chk("rst_flush_cnt", 32'(a.flush_cnt), 0);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a.rs1_ID = tv[i].rs1; a.rs2_ID = tv[i].rs2; a.rd_EX = tv[i].rd;
            a.rs1_used_ID = tv[i].u1; a.rs2_used_ID = tv[i].u2;
            a.mem_read_EX = tv[i].mr; a.branch_taken_EX = tv[i].br;
            #1;
            chk($sformatf("v%0d_pc_en", i), 32'(a.pc_en), 32'(tv[i].pc));
            chk($sformatf("v%0d_redir", i), 32'(a.redirect_sel), 32'(tv[i].rs));
            chk($sformatf("v%0d_ctl", i), 32'(ca), 32'(tv[i].ctl));
            @(negedge clk);
        end
        idle_in();
        chk("tbl_stall_cnt", 32'(a.stall_cnt), 2);
        chk("tbl_flush_cnt", 32'(a.flush_cnt), 2);
        // five busy cycles then release
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            a.mem_busy_MEM = 1;
            #1;
            chk($sformatf("busy%0d_pc_en", i), 32'(a.pc_en), 0);
            chk($sformatf("busy%0d_ctl", i), 32'(ca), 32'(6'b101010));
            @(negedge clk);
        end
        a.mem_busy_MEM = 0;
        #1;
        chk("busy_rel_pc_en", 32'(a.pc_en), 1);
        chk("busy_rel_ctl", 32'(ca), 0);
        chk("busy_stall_cnt", 32'(a.stall_cnt), 5);
        @(negedge clk);
        chk("busy_run_trap_busy", 32'(a.trap_busy), 0);
        // watchdog on dut_b (MEM_TIMEOUT=4)
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            a.mem_busy_MEM = 1;
            #1;
            chk($sformatf("wd%0d_timeout", i), 32'(b.mem_timeout), 0);
            @(negedge clk);
        end
        #1;
        chk("wd4_timeout", 32'(b.mem_timeout), 1);
        chk("wd4_redir", 32'(b.redirect_sel), 2);
        chk("wd4_pc_en", 32'(b.pc_en), 1);
        chk("wd4_ctl", 32'(cb), 32'(6'b010101));
        @(negedge clk); a.mem_busy_MEM = 0;
        #1;
        chk("wd_d1_busy", 32'(b.trap_busy), 1);
        chk("wd_d1_pc_en", 32'(b.pc_en), 0);
        chk("wd_d1_ctl", 32'(cb), 32'(6'b010101));
        @(negedge clk);
        chk("wd_d2_busy", 32'(b.trap_busy), 1);
        @(negedge clk);
        chk("wd_run_busy", 32'(b.trap_busy), 0);
        chk("wd_run_pc_en", 32'(b.pc_en), 1);
        chk("wd_flush_cnt", 32'(b.flush_cnt), 1);
        chk("wd_stall_cnt", 32'(b.stall_cnt), 3);
        // trap beats busy and branch; re-trap in drain reloads
        do_reset();
        a.trap_req = 1; a.mem_busy_MEM = 1; a.branch_taken_EX = 1;
        #1;
        chk("trap_redir", 32'(a.redirect_sel), 2);
        chk("trap_pc_en", 32'(a.pc_en), 1);
        chk("trap_ctl", 32'(ca), 32'(6'b010101));
        @(negedge clk);
        a.trap_req = 0; a.mem_busy_MEM = 0;
        a.mem_read_EX = 1; a.rd_EX = 5; a.rs1_ID = 5; a.rs1_used_ID = 1;
        #1;
        chk("drain_busy", 32'(a.trap_busy), 1);
        chk("drain_pc_en", 32'(a.pc_en), 0);
        chk("drain_redir", 32'(a.redirect_sel), 0);
        chk("drain_ctl", 32'(ca), 32'(6'b010101));
        @(negedge clk); idle_in(); a.trap_req = 1;
        #1;
        chk("retrap_redir", 32'(a.redirect_sel), 2);
        chk("retrap_pc_en", 32'(a.pc_en), 1);
        @(negedge clk); a.trap_req = 0;
        #1;
        chk("retrap_d1", 32'(a.trap_busy), 1);
        @(negedge clk);
        chk("retrap_d2", 32'(a.trap_busy), 1);
        chk("retrap_flush_cnt", 32'(a.flush_cnt), 2);
        @(negedge clk);
        chk("retrap_run", 32'(a.trap_busy), 0);
        // reset in drain
        a.trap_req = 1;
        @(negedge clk); a.trap_req = 0; rst = 1;
        #1;
        chk("rstdrn_busy", 32'(a.trap_busy), 0);
        chk("rstdrn_ctl", 32'(ca), 0);
        @(negedge clk); rst = 0;
        #1;
        chk("rstdrn_run_busy", 32'(a.trap_busy), 0);
        chk("rstdrn_run_pc_en", 32'(a.pc_en), 1);
        chk("rstdrn_flush_cnt", 32'(a.flush_cnt), 0);
        chk("rstdrn_stall_cnt", 32'(a.stall_cnt), 0);
        // saturation of 4-bit counters
        a.mem_busy_MEM = 1;
        repeat (17) @(negedge clk);
        a.mem_busy_MEM = 0;
        chk("sat_stall_cnt", 32'(a.stall_cnt), 15);
        a.branch_taken_EX = 1;
        repeat (17) @(negedge clk);
        a.branch_taken_EX = 0;
        chk("sat_flush_cnt", 32'(a.flush_cnt), 15);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
